// File: rtl/hvtx_timing_gen.sv
// Runtime-programmable video timing generator: pixel cursor, HS/VS/DE, TMDS preamble/guard flags.
// Define HVTX_TIMING_STATS_EN to add the o_frame_cnt / o_cfg_applied statistics outputs.
module hvtx_timing_gen #(
  parameter int WID      = 12,
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_cfg_valid,
  output logic           o_cfg_ready,
  input  logic [WID-1:0] i_cfg_h_active,
  input  logic [WID-1:0] i_cfg_h_fp,
  input  logic [WID-1:0] i_cfg_h_sync,
  input  logic [WID-1:0] i_cfg_h_bp,
  input  logic [WID-1:0] i_cfg_v_active,
  input  logic [WID-1:0] i_cfg_v_fp,
  input  logic [WID-1:0] i_cfg_v_sync,
  input  logic [WID-1:0] i_cfg_v_bp,
  input  logic           i_cfg_hs_pol,
  input  logic           i_cfg_vs_pol,
  output logic           o_cfg_err,
  output logic [WID-1:0] o_x,
  output logic [WID-1:0] o_y,
  output logic           o_hs,
  output logic           o_vs,
  output logic           o_de,
  output logic           o_preamble,
  output logic           o_guard,
  output logic           o_frame_start
`ifdef HVTX_TIMING_STATS_EN
  ,
  output logic [15:0]    o_frame_cnt,
  output logic           o_cfg_applied
`endif
);

  localparam int SW = WID + 2;
  localparam logic [SW-1:0] TOT_MAX = SW'((1 << WID) - 1);
  localparam logic [SW-1:0] TOT_MIN = SW'(12);

  typedef struct packed {
    logic [WID-1:0] h_active;
    logic [WID-1:0] h_fp;
    logic [WID-1:0] h_sync;
    logic [WID-1:0] h_bp;
    logic [WID-1:0] v_active;
    logic [WID-1:0] v_fp;
    logic [WID-1:0] v_sync;
    logic [WID-1:0] v_bp;
    logic           hs_pol;
    logic           vs_pol;
  } timing_t;

  localparam timing_t TIMING_DEFAULT = '{
    h_active: WID'(H_ACTIVE), h_fp: WID'(H_FP), h_sync: WID'(H_SYNC), h_bp: WID'(H_BP),
    v_active: WID'(V_ACTIVE), v_fp: WID'(V_FP), v_sync: WID'(V_SYNC), v_bp: WID'(V_BP),
    hs_pol: HS_POL, vs_pol: VS_POL
  };

  typedef enum logic {CFG_IDLE, CFG_PENDING} cfg_state_t;

  cfg_state_t     state;
  timing_t        act;
  timing_t        shadow;
  timing_t        cfg_in;
  logic [WID-1:0] x;
  logic [WID-1:0] y;

  // Offered configuration: legality is judged on sums wide enough not to wrap.
  logic [SW-1:0] cfg_h_tot;
  logic [SW-1:0] cfg_v_tot;
  logic          cfg_legal;
  logic          cfg_fire;

  assign cfg_in = '{
    h_active: i_cfg_h_active, h_fp: i_cfg_h_fp, h_sync: i_cfg_h_sync, h_bp: i_cfg_h_bp,
    v_active: i_cfg_v_active, v_fp: i_cfg_v_fp, v_sync: i_cfg_v_sync, v_bp: i_cfg_v_bp,
    hs_pol: i_cfg_hs_pol, vs_pol: i_cfg_vs_pol
  };
  assign cfg_h_tot = SW'(i_cfg_h_active) + SW'(i_cfg_h_fp) + SW'(i_cfg_h_sync) + SW'(i_cfg_h_bp);
  assign cfg_v_tot = SW'(i_cfg_v_active) + SW'(i_cfg_v_fp) + SW'(i_cfg_v_sync) + SW'(i_cfg_v_bp);
  assign cfg_legal = (|i_cfg_h_active) && (|i_cfg_h_sync) && (|i_cfg_v_active) && (|i_cfg_v_sync)
                  && (cfg_h_tot >= TOT_MIN) && (cfg_h_tot <= TOT_MAX) && (cfg_v_tot <= TOT_MAX);

  // Handshake: a transfer happens on any clock where i_cfg_valid && o_cfg_ready; ready is
  // low exactly while an accepted configuration waits in the shadow for the frame wrap.
  assign o_cfg_ready = (state == CFG_IDLE);
  assign cfg_fire    = i_cfg_valid && o_cfg_ready;

  // Landmarks of the active timing; legal sets always fit in WID bits.
  logic [WID-1:0] hs_start, hs_end, h_tot, vs_start, vs_end, v_tot;
  logic [WID-1:0] pre_start, pre_end, guard_start;
  logic           last_x, last_y, wrap;
  logic           hs_act, vs_act, de_c, pg_line, pre_c, guard_c, fs_c;

  assign hs_start    = act.h_active + act.h_fp;
  assign hs_end      = hs_start + act.h_sync;
  assign h_tot       = hs_end + act.h_bp;
  assign vs_start    = act.v_active + act.v_fp;
  assign vs_end      = vs_start + act.v_sync;
  assign v_tot       = vs_end + act.v_bp;
  assign pre_start   = h_tot - WID'(10);
  assign pre_end     = h_tot - WID'(3);
  assign guard_start = h_tot - WID'(2);

  assign last_x  = (x == h_tot - WID'(1));
  assign last_y  = (y == v_tot - WID'(1));
  assign wrap    = last_x && last_y;
  assign hs_act  = (x >= hs_start) && (x < hs_end);
  assign de_c    = (x < act.h_active) && (y < act.v_active);
  // VS edges line up with the HS leading edge on the first and last sync lines.
  assign vs_act  = ((y > vs_start) || ((y == vs_start) && (x >= hs_start)))
                && ((y < vs_end)   || ((y == vs_end)   && (x <  hs_start)));
  assign pg_line = (y < act.v_active - WID'(1)) || last_y;
  assign pre_c   = pg_line && (x >= pre_start) && (x <= pre_end);
  assign guard_c = pg_line && (x >= guard_start);
  assign fs_c    = (x == '0) && (y == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= CFG_IDLE;
      act           <= TIMING_DEFAULT;
      shadow        <= TIMING_DEFAULT;
      x             <= '0;
      y             <= '0;
      o_x           <= '0;
      o_y           <= '0;
      o_hs          <= ~HS_POL;
      o_vs          <= ~VS_POL;
      o_de          <= 1'b0;
      o_preamble    <= 1'b0;
      o_guard       <= 1'b0;
      o_frame_start <= 1'b0;
      o_cfg_err     <= 1'b0;
    end else begin
      o_x           <= x;
      o_y           <= y;
      o_hs          <= hs_act ? act.hs_pol : ~act.hs_pol;
      o_vs          <= vs_act ? act.vs_pol : ~act.vs_pol;
      o_de          <= de_c;
      o_preamble    <= pre_c;
      o_guard       <= guard_c;
      o_frame_start <= fs_c;
      o_cfg_err     <= cfg_fire && !cfg_legal;

      if (last_x) begin
        x <= '0;
        y <= last_y ? '0 : y + WID'(1);
      end else begin
        x <= x + WID'(1);
      end

      case (state)
        CFG_IDLE: begin
          if (cfg_fire && cfg_legal) begin
            shadow <= cfg_in;
            state  <= CFG_PENDING;
          end
        end
        CFG_PENDING: begin
          if (wrap) begin
            act   <= shadow;
            state <= CFG_IDLE;
          end
        end
        default: state <= CFG_IDLE;
      endcase
    end
  end

`ifdef HVTX_TIMING_STATS_EN
  logic applied_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frame_cnt   <= '0;
      o_cfg_applied <= 1'b0;
      applied_d     <= 1'b0;
    end else begin
      if (fs_c) o_frame_cnt <= o_frame_cnt + 16'd1;
      applied_d     <= (state == CFG_PENDING) && wrap;
      o_cfg_applied <= applied_d && fs_c;
    end
  end
`else
  // Statistics disabled: no counter state exists in this build.
`endif

endmodule

// File: tb/tb_hvtx_timing_gen.sv
// Directed bench: a 720p-default instance for line-level checks and a small-timing
// instance for frame-level behaviour (config apply, VS, preamble lines, reset).
module tb_hvtx_timing_gen;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        d_valid = 1'b0;
  logic        s_valid = 1'b0;
  logic [11:0] c_ha = '0, c_hfp = '0, c_hs = '0, c_hbp = '0;
  logic [11:0] c_va = '0, c_vfp = '0, c_vs = '0, c_vbp = '0;
  logic        c_hpol = 1'b0, c_vpol = 1'b0;

  logic        d_ready, d_err, d_hs, d_vs, d_de, d_pre, d_guard, d_fs;
  logic [11:0] d_x, d_y;
  logic        s_ready, s_err, s_hs, s_vs, s_de, s_pre, s_guard, s_fs;
  logic [11:0] s_x, s_y;
`ifdef HVTX_TIMING_STATS_EN
  logic [15:0] d_fcnt, s_fcnt;
  logic        d_applied, s_applied;
`endif

  always #5 i_clk = ~i_clk;

  hvtx_timing_gen u_def (
    .i_clk(i_clk), .i_rst(i_rst), .i_cfg_valid(d_valid), .o_cfg_ready(d_ready),
    .i_cfg_h_active(c_ha), .i_cfg_h_fp(c_hfp), .i_cfg_h_sync(c_hs), .i_cfg_h_bp(c_hbp),
    .i_cfg_v_active(c_va), .i_cfg_v_fp(c_vfp), .i_cfg_v_sync(c_vs), .i_cfg_v_bp(c_vbp),
    .i_cfg_hs_pol(c_hpol), .i_cfg_vs_pol(c_vpol), .o_cfg_err(d_err),
    .o_x(d_x), .o_y(d_y), .o_hs(d_hs), .o_vs(d_vs), .o_de(d_de),
    .o_preamble(d_pre), .o_guard(d_guard), .o_frame_start(d_fs)
`ifdef HVTX_TIMING_STATS_EN
    , .o_frame_cnt(d_fcnt), .o_cfg_applied(d_applied)
`endif
  );

  hvtx_timing_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .i_clk(i_clk), .i_rst(i_rst), .i_cfg_valid(s_valid), .o_cfg_ready(s_ready),
    .i_cfg_h_active(c_ha), .i_cfg_h_fp(c_hfp), .i_cfg_h_sync(c_hs), .i_cfg_h_bp(c_hbp),
    .i_cfg_v_active(c_va), .i_cfg_v_fp(c_vfp), .i_cfg_v_sync(c_vs), .i_cfg_v_bp(c_vbp),
    .i_cfg_hs_pol(c_hpol), .i_cfg_vs_pol(c_vpol), .o_cfg_err(s_err),
    .o_x(s_x), .o_y(s_y), .o_hs(s_hs), .o_vs(s_vs), .o_de(s_de),
    .o_preamble(s_pre), .o_guard(s_guard), .o_frame_start(s_fs)
`ifdef HVTX_TIMING_STATS_EN
    , .o_frame_cnt(s_fcnt), .o_cfg_applied(s_applied)
`endif
  );

  // Instance selected for the measuring tasks: 0 = default, 1 = small.
  bit          sel = 1'b0;
  logic [11:0] m_x, m_y;
  logic        m_hs, m_vs, m_de, m_pre, m_guard, m_fs, m_ready;
  assign m_x     = sel ? s_x     : d_x;
  assign m_y     = sel ? s_y     : d_y;
  assign m_hs    = sel ? s_hs    : d_hs;
  assign m_vs    = sel ? s_vs    : d_vs;
  assign m_de    = sel ? s_de    : d_de;
  assign m_pre   = sel ? s_pre   : d_pre;
  assign m_guard = sel ? s_guard : d_guard;
  assign m_fs    = sel ? s_fs    : d_fs;
  assign m_ready = sel ? s_ready : d_ready;

  int checks = 0;
  int errors = 0;

  int ln_len, ln_de, ln_hs_first, ln_hs_n, ln_pre_first, ln_pre_n, ln_g_first, ln_g_n, ln_vs_n;
  int fr_len, fr_de, fr_hs_first, fr_hs_n, fr_vs_x, fr_vs_y, fr_vs_n, fr_pre_first, fr_g_first;
  int pre_line[16];
  int g_line[16];

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int ha, hfp, hs, hbp, va, vfp, vs, vbp, input logic hp, vp);
    c_ha = 12'(ha); c_hfp = 12'(hfp); c_hs = 12'(hs); c_hbp = 12'(hbp);
    c_va = 12'(va); c_vfp = 12'(vfp); c_vs = 12'(vs); c_vbp = 12'(vbp);
    c_hpol = hp; c_vpol = vp;
  endtask

  task automatic wait_pixel(input string tag, input int px, input int py, input int bound);
    int n = 0;
    while (!(m_x == 12'(px) && m_y == 12'(py)) && n < bound) begin
      step();
      n++;
    end
    check(tag, 32'(m_x == 12'(px) && m_y == 12'(py)), 32'd1);
  endtask

  // Starts on a sample showing x=0 and stops on the next one.
  task automatic measure_line(input logic hp, input logic vp);
    ln_len = 0; ln_de = 0; ln_hs_first = -1; ln_hs_n = 0; ln_pre_first = -1;
    ln_pre_n = 0; ln_g_first = -1; ln_g_n = 0; ln_vs_n = 0;
    do begin
      if (m_de === 1'b1) ln_de++;
      if (m_hs === hp) begin if (ln_hs_n == 0) ln_hs_first = int'(m_x); ln_hs_n++; end
      if (m_vs === vp) ln_vs_n++;
      if (m_pre === 1'b1) begin if (ln_pre_n == 0) ln_pre_first = int'(m_x); ln_pre_n++; end
      if (m_guard === 1'b1) begin if (ln_g_n == 0) ln_g_first = int'(m_x); ln_g_n++; end
      step();
      ln_len++;
    end while (m_x !== 12'd0 && ln_len < 5000);
  endtask

  // Starts on a frame-start sample and stops on the next frame start.
  task automatic scan_frame(input logic hp, input logic vp);
    fr_len = 0; fr_de = 0; fr_hs_first = -1; fr_hs_n = 0; fr_vs_x = -1; fr_vs_y = -1;
    fr_vs_n = 0; fr_pre_first = -1; fr_g_first = -1;
    for (int i = 0; i < 16; i++) begin pre_line[i] = 0; g_line[i] = 0; end
    do begin
      if (m_de === 1'b1) fr_de++;
      if (m_hs === hp) begin if (fr_hs_n == 0) fr_hs_first = int'(m_x); fr_hs_n++; end
      if (m_vs === vp) begin
        if (fr_vs_n == 0) begin fr_vs_x = int'(m_x); fr_vs_y = int'(m_y); end
        fr_vs_n++;
      end
      if (m_pre === 1'b1) begin
        if (fr_pre_first < 0) fr_pre_first = int'(m_x);
        if (m_y < 12'd16) pre_line[m_y[3:0]]++;
      end
      if (m_guard === 1'b1) begin
        if (fr_g_first < 0) fr_g_first = int'(m_x);
        if (m_y < 12'd16) g_line[m_y[3:0]]++;
      end
      step();
      fr_len++;
    end while (m_fs !== 1'b1 && fr_len < 5000);
  endtask

  initial begin
    // Reset values
    step(); step();
    check("rst_x", 32'(d_x), 0);
    check("rst_y", 32'(d_y), 0);
    check("rst_de", 32'(d_de), 0);
    check("rst_hs", 32'(d_hs), 0);
    check("rst_vs", 32'(d_vs), 0);
    check("rst_ready", 32'(d_ready), 1);
    check("rst_err", 32'(d_err), 0);
    check("rst_fs", 32'(d_fs), 0);
    check("rst_pre_guard", 32'({d_pre, d_guard}), 0);

    // First cycle after release shows pixel (0,0)
    i_rst = 1'b0;
    step();
    check("first_x", 32'(d_x), 0);
    check("first_y", 32'(d_y), 0);
    check("first_de", 32'(d_de), 1);
    check("first_fs", 32'(d_fs), 1);
    check("small_first_fs", 32'(s_fs), 1);
`ifdef HVTX_TIMING_STATS_EN
    check("first_fcnt", 32'(s_fcnt), 1);
`endif

    // 720p line 0
    sel = 1'b0;
    measure_line(1'b1, 1'b1);
    check("l0_len", ln_len, 1650);
    check("l0_de", ln_de, 1280);
    check("l0_hs_first", ln_hs_first, 1390);
    check("l0_hs_n", ln_hs_n, 40);
    check("l0_pre_first", ln_pre_first, 1640);
    check("l0_pre_n", ln_pre_n, 8);
    check("l0_g_first", ln_g_first, 1648);
    check("l0_g_n", ln_g_n, 2);
    check("l0_vs_n", ln_vs_n, 0);
    check("l1_y", 32'(d_y), 1);

    // Rejected: h_sync = 0
    set_cfg(1280, 110, 0, 220, 720, 5, 5, 20, 1'b1, 1'b1);
    d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    check("rej_hs0_err", 32'(d_err), 1);
    check("rej_hs0_ready", 32'(d_ready), 1);
    step();
    check("rej_hs0_err_end", 32'(d_err), 0);
    check("rej_hs0_ready2", 32'(d_ready), 1);

    // Rejected: H_TOT = 11
    set_cfg(4, 2, 3, 2, 4, 1, 1, 1, 1'b0, 1'b0);
    d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    check("rej_h11_err", 32'(d_err), 1);
    check("rej_h11_ready", 32'(d_ready), 1);
    step();
    check("rej_h11_err_end", 32'(d_err), 0);

    // Timing unchanged after rejections
    wait_pixel("wait_l2", 0, 2, 2000);
    measure_line(1'b1, 1'b1);
    check("l2_len", ln_len, 1650);
    check("l2_hs_first", ln_hs_first, 1390);
    check("l2_hs_n", ln_hs_n, 40);
    check("l2_de", ln_de, 1280);

    // Small instance, reset-default timing: H 20/3/4/5, V 6/2/2/3
    sel = 1'b1;
    wait_pixel("wait_small_fs", 0, 0, 500);
    scan_frame(1'b1, 1'b1);
    check("sd_len", fr_len, 416);
    check("sd_de", fr_de, 120);
    check("sd_hs_first", fr_hs_first, 23);
    check("sd_hs_n", fr_hs_n, 52);
    check("sd_vs_x", fr_vs_x, 23);
    check("sd_vs_y", fr_vs_y, 8);
    check("sd_vs_n", fr_vs_n, 64);
    check("sd_pre_first", fr_pre_first, 22);
    check("sd_g_first", fr_g_first, 30);
    check("sd_pre_l0", pre_line[0], 8);
    check("sd_pre_l4", pre_line[4], 8);
    check("sd_pre_l5", pre_line[5], 0);
    check("sd_g_l5", g_line[5], 0);
    check("sd_pre_l11", pre_line[11], 0);
    check("sd_pre_l12", pre_line[12], 8);
    check("sd_g_l12", g_line[12], 2);

    // Mid-frame configuration H 16/2/4/2, V 4/1/1/1, polarity 0/0
    wait_pixel("wait_y3", 0, 3, 500);
    set_cfg(16, 2, 4, 2, 4, 1, 1, 1, 1'b0, 1'b0);
    check("cfg_ready_before", 32'(s_ready), 1);
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    check("cfg_ready_after", 32'(s_ready), 0);
    check("cfg_err_legal", 32'(s_err), 0);
    begin
      int n = 0;
      int bad = 0;
      while (!(m_x == 12'd31 && m_y == 12'd12) && n < 1000) begin
        if (m_ready !== 1'b0) bad++;
        step();
        n++;
      end
      check("cfg_ready_low_cycles", bad, 0);
      check("cfg_reach_wrap", 32'(m_x == 12'd31 && m_y == 12'd12), 1);
    end
    check("cfg_ready_back", 32'(s_ready), 1);
    step();
    check("new_fs", 32'(s_fs), 1);
    check("new_x", 32'(s_x), 0);
    check("new_y", 32'(s_y), 0);
`ifdef HVTX_TIMING_STATS_EN
    check("applied_pulse", 32'(s_applied), 1);
`endif
    scan_frame(1'b0, 1'b0);
    check("nf_len", fr_len, 168);
    check("nf_de", fr_de, 64);
    check("nf_hs_first", fr_hs_first, 18);
    check("nf_hs_n", fr_hs_n, 28);
    check("nf_vs_x", fr_vs_x, 18);
    check("nf_vs_y", fr_vs_y, 5);
    check("nf_vs_n", fr_vs_n, 24);
    check("nf_pre_first", fr_pre_first, 14);
    check("nf_g_first", fr_g_first, 22);
    check("nf_pre_l3", pre_line[3], 0);
    check("nf_pre_l6", pre_line[6], 8);
    check("nf_g_l6", g_line[6], 2);
`ifdef HVTX_TIMING_STATS_EN
    check("applied_once", 32'(s_applied), 0);
`endif

    // Reset mid-frame with a configuration pending
    wait_pixel("wait_pend", 5, 2, 500);
    set_cfg(30, 4, 4, 4, 8, 2, 2, 2, 1'b1, 1'b1);
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    check("pend_ready", 32'(s_ready), 0);
    step(); step();
    i_rst = 1'b1;
    step();
    check("mrst_ready", 32'(s_ready), 1);
    check("mrst_hs", 32'(s_hs), 0);
    check("mrst_vs", 32'(s_vs), 0);
    check("mrst_de", 32'(s_de), 0);
    check("mrst_xy", 32'({s_x, s_y}), 0);
    i_rst = 1'b0;
    step();
    check("mrst_fs", 32'(s_fs), 1);
    check("mrst_de1", 32'(s_de), 1);
    check("mrst_xy1", 32'({s_x, s_y}), 0);
    scan_frame(1'b1, 1'b1);
    check("mrst_f1_len", fr_len, 416);
    check("mrst_f1_hs_first", fr_hs_first, 23);
    check("mrst_f1_vs_y", fr_vs_y, 8);
    scan_frame(1'b1, 1'b1);
    check("mrst_f2_len", fr_len, 416);
    check("mrst_f2_de", fr_de, 120);
    check("mrst_f2_ready", 32'(s_ready), 1);
`ifdef HVTX_TIMING_STATS_EN
    check("fcnt_3", 32'(s_fcnt), 3);
    check("no_applied_after_rst", 32'(s_applied), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
